// File: rtl/interval_counter_pkg.sv
// Shared definitions for the interval counter: mode codes, state encodings, mode decode.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package interval_counter_pkg;

  typedef enum logic [1:0] {
    MODE_FREE    = 2'b00,
    MODE_ONESHOT = 2'b01,
    MODE_LEGACY  = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // The spare code 2'b11 behaves as free-run.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return MODE_ONESHOT;
      2'b10:   return MODE_LEGACY;
      default: return MODE_FREE;
    endcase
  endfunction

endpackage

// File: rtl/interval_counter_tick_prescaler.sv
// Divides count-enable cycles by PRESC into a single-cycle prescaled tick.
// Latency: presc_tick is combinational on en and the registered phase counter.
// Backpressure: none; the phase advances only while en=1, sclr restarts the phase.
//  Ports: clk, clr (async active-high), en (advance), sclr (sync phase clear),
//         presc_tick (high on the en cycle where the phase reaches PRESC-1).
module interval_counter_tick_prescaler #(
  parameter int PRESC = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic sclr,
  output logic presc_tick
);

  localparam int CW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESC - 1);

  logic [CW-1:0] phase;

  // With PRESC=1 the phase is pinned at 0 == LAST, so every en cycle ticks.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      phase <= '0;
    end else if (sclr) begin
      phase <= '0;
    end else if (en) begin
      phase <= (phase == LAST) ? '0 : phase + 1'b1;
    end
  end

  assign presc_tick = en && (phase == LAST);

endmodule

// File: rtl/interval_counter.sv
// Programmable terminal-count interval counter with free-run, one-shot and legacy modes.
// Latency: q/cy/tc/done/running/wrap_cnt all registered; cy lags q by one cycle.
// Backpressure: none; en gates counting, edge priority is ld > stop > start > tick.
//  Ports: clk, clr (async active-high); d/ld load; en; max_in/max_ld terminal count;
//         mode/start/stop control; q, cy, tc, done, running, wrap_cnt status.
module interval_counter
  import interval_counter_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int MAX    = 50000,
  parameter int PRESC  = 1,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [WIDTH-1:0]  d,
  input  logic              ld,
  input  logic              en,
  input  logic [WIDTH-1:0]  max_in,
  input  logic              max_ld,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic              stop,
  output logic [WIDTH-1:0]  q,
  output logic              cy,
  output logic              tc,
  output logic              done,
  output logic              running,
  output logic [WRAP_W-1:0] wrap_cnt
);

  localparam logic [WIDTH-1:0] MAX_INIT = WIDTH'(MAX);

  state_e             state, state_nxt;
  mode_e              mode_r;
  logic [WIDTH-1:0]   cnt;
  logic [WIDTH-1:0]   max_r;
  logic [WRAP_W-1:0]  wrap_r;
  logic               cy_r, tc_r;
  logic               presc_tick, tick;
  logic               act_start, run_tick, term, hit;

  // stop overrides start, so a start that loses to stop has no side effects.
  assign act_start = start & ~stop;

  interval_counter_tick_prescaler #(
    .PRESC (PRESC)
  ) u_tick_prescaler (
    .clk        (clk),
    .clr        (clr),
    .en         (en),
    .sclr       (ld | act_start),
    .presc_tick (presc_tick)
  );

  assign tick     = en & presc_tick;
  // A tick only counts in RUN and when no higher-priority control owns the edge.
  assign run_tick = tick & (state == ST_RUN) & ~ld & ~stop & ~start;
  assign term     = (cnt >= max_r);
  assign hit      = run_tick & (mode_r != MODE_LEGACY) & term;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = ST_IDLE;
    end else if (start) begin
      state_nxt = ST_RUN;
    end else if (hit && (mode_r == MODE_ONESHOT)) begin
      state_nxt = ST_DONE;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= d;
    end else if (stop) begin
      cnt <= cnt;
    end else if (start) begin
      cnt <= '0;
    end else if (run_tick) begin
      if (mode_r == MODE_LEGACY) begin
        cnt <= cnt + 1'b1;
      end else if (term) begin
        // One-shot parks on the terminal value; free-run wraps to zero.
        cnt <= (mode_r == MODE_FREE) ? '0 : cnt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      max_r  <= MAX_INIT;
      mode_r <= MODE_FREE;
      wrap_r <= '0;
      cy_r   <= 1'b0;
      tc_r   <= 1'b0;
    end else begin
      if (max_ld) begin
        max_r <= max_in;
      end
      if (act_start) begin
        mode_r <= decode_mode(mode);
      end
      if (act_start) begin
        wrap_r <= '0;
      end else if (hit && (wrap_r != {WRAP_W{1'b1}})) begin
        wrap_r <= wrap_r + 1'b1;
      end
      cy_r <= term;
      tc_r <= hit;
    end
  end

  assign q        = cnt;
  assign cy       = cy_r;
  assign tc       = tc_r;
  assign done     = (state == ST_DONE);
  assign running  = (state == ST_RUN);
  assign wrap_cnt = wrap_r;

endmodule
